// File: rtl/rx_ipv4_hdr.sv
// rx_ipv4_hdr: IPv4 receive header parser. Validates the header of each frame
// and forwards accepted UDP/TCP payload bytes one cycle later with a
// per-protocol strobe; rejected or truncated frames raise a one-cycle pulse.
module rx_ipv4_hdr #(
  parameter int unsigned OCT       = 8,
  parameter logic [7:0]  PROTO_UDP = 8'd17,
  parameter logic [7:0]  PROTO_TCP = 8'd6
) (
  input  logic           RX_CLK,
  input  logic           rst,
  input  logic [31:0]    ip_addr,
  input  logic           rx_payload_ipv4,
  input  logic [OCT-1:0] rx_payload,
  output logic           rx_data_udp,
  output logic           rx_data_tcp,
  output logic [OCT-1:0] rx_data,
  output logic           rx_data_last,
  output logic [15:0]    rx_data_len,
  output logic [31:0]    rx_src_ip,
  output logic           rx_drop,
  output logic           rx_trunc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_DROP
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           armed_q, armed_d;
  logic [3:0]     ver_q, ver_d;
  logic [3:0]     ihl_q, ihl_d;
  logic [15:0]    tl_q, tl_d;
  logic           mf_q, mf_d;
  logic [12:0]    frag_q, frag_d;
  logic [7:0]     proto_q, proto_d;
  logic [31:0]    src_q, src_d;
  logic [31:0]    dst_q, dst_d;
  logic [OCT-1:0] hi_q, hi_d;
  logic [16:0]    csum_q, csum_d;

  logic           udp_q, udp_d;
  logic           tcp_q, tcp_d;
  logic [OCT-1:0] data_q, data_d;
  logic           last_q, last_d;
  logic [15:0]    len_q, len_d;
  logic [31:0]    src_ip_q, src_ip_d;
  logic           drop_q, drop_d;
  logic           trunc_q, trunc_d;

  logic           hdr_byte;
  logic [15:0]    word;
  logic [16:0]    sum17;
  logic [15:0]    fold;
  logic [15:0]    hl;
  logic [15:0]    pay_len;
  logic [15:0]    hdr_end_idx;
  logic           chk_ok;

  // State, header fields and registered outputs.
  always_ff @(posedge RX_CLK or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      ver_q    <= '0;
      ihl_q    <= '0;
      tl_q     <= '0;
      mf_q     <= 1'b0;
      frag_q   <= '0;
      proto_q  <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      hi_q     <= '0;
      csum_q   <= '0;
      udp_q    <= 1'b0;
      tcp_q    <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      len_q    <= '0;
      src_ip_q <= '0;
      drop_q   <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      ver_q    <= ver_d;
      ihl_q    <= ihl_d;
      tl_q     <= tl_d;
      mf_q     <= mf_d;
      frag_q   <= frag_d;
      proto_q  <= proto_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      hi_q     <= hi_d;
      csum_q   <= csum_d;
      udp_q    <= udp_d;
      tcp_q    <= tcp_d;
      data_q   <= data_d;
      last_q   <= last_d;
      len_q    <= len_d;
      src_ip_q <= src_ip_d;
      drop_q   <= drop_d;
      trunc_q  <= trunc_d;
    end
  end

  // Header capture, checksum accumulation, checks and next-state selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    // After reset the frame in flight is ignored until a gap is observed.
    armed_d  = armed_q | ~rx_payload_ipv4;
    ver_d    = ver_q;
    ihl_d    = ihl_q;
    tl_d     = tl_q;
    mf_d     = mf_q;
    frag_d   = frag_q;
    proto_d  = proto_q;
    src_d    = src_q;
    dst_d    = dst_q;
    hi_d     = hi_q;
    csum_d   = csum_q;
    udp_d    = 1'b0;
    tcp_d    = 1'b0;
    data_d   = data_q;
    last_d   = 1'b0;
    len_d    = len_q;
    src_ip_d = src_ip_q;
    drop_d   = 1'b0;
    trunc_d  = 1'b0;

    hdr_byte = rx_payload_ipv4 &&
               ((state_q == S_IDLE && armed_q) || state_q == S_HDR);

    // End-around add of the completed 16-bit word; one more fold gives the
    // final ones-complement sum when this is the last header byte.
    word  = {hi_q, rx_payload};
    sum17 = {1'b0, csum_q[15:0]} + {1'b0, word} + {16'd0, csum_q[16]};
    fold  = sum17[15:0] + {15'd0, sum17[16]};

    if (hdr_byte) begin
      if (cnt_q[0]) csum_d = sum17;
      else          hi_d   = rx_payload;
      case (cnt_q)
        16'd0:  begin ver_d = rx_payload[7:4]; ihl_d = rx_payload[3:0]; end
        16'd2:  tl_d[15:8] = rx_payload;
        16'd3:  tl_d[7:0]  = rx_payload;
        16'd6:  begin mf_d = rx_payload[5]; frag_d[12:8] = rx_payload[4:0]; end
        16'd7:  frag_d[7:0] = rx_payload;
        16'd9:  proto_d = rx_payload;
        16'd12: src_d[31:24] = rx_payload;
        16'd13: src_d[23:16] = rx_payload;
        16'd14: src_d[15:8]  = rx_payload;
        16'd15: src_d[7:0]   = rx_payload;
        16'd16: dst_d[31:24] = rx_payload;
        16'd17: dst_d[23:16] = rx_payload;
        16'd18: dst_d[15:8]  = rx_payload;
        16'd19: dst_d[7:0]   = rx_payload;
        default: ;
      endcase
    end

    // An IHL below 5 still runs to byte 19 so the failure is reported there.
    hl          = {10'd0, ihl_q, 2'b00};
    hdr_end_idx = (ihl_q < 4'd5) ? 16'd19 : (hl - 16'd1);
    pay_len     = tl_d - hl;
    chk_ok      = (ver_d == 4'd4) && (ihl_q >= 4'd5) && (tl_d >= hl) &&
                  (fold == 16'hFFFF) &&
                  ((dst_d == ip_addr) || (dst_d == 32'hFFFF_FFFF)) &&
                  !mf_d && (frag_d == '0) &&
                  ((proto_d == PROTO_UDP) || (proto_d == PROTO_TCP));

    case (state_q)
      S_IDLE: begin
        if (hdr_byte) begin
          state_d = S_HDR;
          cnt_d   = 16'd1;
        end else begin
          cnt_d  = '0;
          csum_d = '0;
        end
      end
      S_HDR: begin
        if (!rx_payload_ipv4) begin
          drop_d  = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
          csum_d  = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == hdr_end_idx) begin
            if (chk_ok) begin
              len_d    = pay_len;
              src_ip_d = src_d;
              state_d  = (pay_len == '0) ? S_DONE : S_DATA;
            end else begin
              drop_d  = 1'b1;
              state_d = S_DROP;
            end
          end
        end
      end
      S_DATA: begin
        if (!rx_payload_ipv4) begin
          trunc_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = '0;
          csum_d  = '0;
        end else begin
          cnt_d  = cnt_q + 16'd1;
          data_d = rx_payload;
          udp_d  = (proto_q == PROTO_UDP);
          tcp_d  = (proto_q == PROTO_TCP);
          if (cnt_q == tl_q - 16'd1) begin
            last_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE, S_DROP: begin
        if (!rx_payload_ipv4) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          csum_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        csum_d  = '0;
      end
    endcase
  end

  assign rx_data_udp  = udp_q;
  assign rx_data_tcp  = tcp_q;
  assign rx_data      = data_q;
  assign rx_data_last = last_q;
  assign rx_data_len  = len_q;
  assign rx_src_ip    = src_ip_q;
  assign rx_drop      = drop_q;
  assign rx_trunc     = trunc_q;

endmodule

// File: tb/tb_rx_ipv4_hdr.sv
// tb_rx_ipv4_hdr: directed frames against hand-computed expectations for the
// IPv4 receive header parser.
module tb_rx_ipv4_hdr;

  localparam logic [31:0] MY_IP = 32'hC0A8_010A;

  logic        RX_CLK = 1'b0;
  logic        rst;
  logic [31:0] ip_addr;
  logic        rx_payload_ipv4;
  logic [7:0]  rx_payload;
  logic        rx_data_udp;
  logic        rx_data_tcp;
  logic [7:0]  rx_data;
  logic        rx_data_last;
  logic [15:0] rx_data_len;
  logic [31:0] rx_src_ip;
  logic        rx_drop;
  logic        rx_trunc;

  rx_ipv4_hdr dut (
    .RX_CLK          (RX_CLK),
    .rst             (rst),
    .ip_addr         (ip_addr),
    .rx_payload_ipv4 (rx_payload_ipv4),
    .rx_payload      (rx_payload),
    .rx_data_udp     (rx_data_udp),
    .rx_data_tcp     (rx_data_tcp),
    .rx_data         (rx_data),
    .rx_data_last    (rx_data_last),
    .rx_data_len     (rx_data_len),
    .rx_src_ip       (rx_src_ip),
    .rx_drop         (rx_drop),
    .rx_trunc        (rx_trunc)
  );

  always #5 RX_CLK = ~RX_CLK;

  // Stimulus stream: one entry per cycle, byte plus frame-valid flag.
  logic [7:0] sb [0:511];
  logic       sv [0:511];
  int         slen;
  int         fb;
  int         in_idx;

  int n_cmp;
  int n_err;

  // Monitor tallies.
  int n_udp, n_tcp, n_last, n_last_bad, n_drop, n_trunc, n_dbad, n_runs;
  int first_idx, last_idx, str_idx, drop_idx, trunc_idx;
  logic prev_str;

  // Reset snapshot.
  logic        pre_udp;
  logic [4:0]  snap_flags;
  logic [7:0]  snap_data;
  logic [15:0] snap_len;
  logic [31:0] snap_src;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic mon_clear();
    n_udp = 0; n_tcp = 0; n_last = 0; n_last_bad = 0; n_drop = 0; n_trunc = 0;
    n_dbad = 0; n_runs = 0;
    first_idx = -1; last_idx = -1; str_idx = -1; drop_idx = -1; trunc_idx = -1;
    prev_str = 1'b0;
  endtask

  // Output sampling 1 time unit after each rising edge; in_idx still names
  // the byte the DUT just consumed, so a strobe here carries that byte.
  always @(posedge RX_CLK) begin
    #1;
    if (rx_data_udp) n_udp++;
    if (rx_data_tcp) n_tcp++;
    if (rx_data_udp || rx_data_tcp) begin
      if (first_idx < 0) first_idx = in_idx;
      if (rx_data !== sb[in_idx]) n_dbad++;
      if (!prev_str) n_runs++;
      str_idx = in_idx;
    end
    if (rx_data_last) begin
      n_last++;
      last_idx = in_idx;
      if (!(rx_data_udp || rx_data_tcp)) n_last_bad++;
    end
    if (rx_drop)  begin n_drop++;  drop_idx  = in_idx; end
    if (rx_trunc) begin n_trunc++; trunc_idx = in_idx; end
    prev_str = rx_data_udp || rx_data_tcp;
  end

  task automatic s_new();
    slen = 0;
  endtask

  task automatic s_byte(input logic [7:0] b, input logic v);
    sb[slen] = b;
    sv[slen] = v;
    slen++;
  endtask

  task automatic s_gap(input int n);
    for (int i = 0; i < n; i++) s_byte(8'h00, 1'b0);
  endtask

  task automatic s_pad(input int n);
    for (int i = 0; i < n; i++) s_byte(8'hEE, 1'b1);
  endtask

  task automatic s_pay(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) s_byte(base + 8'(i), 1'b1);
  endtask

  // Header with source C0A80101; IHL 6 appends four zero option bytes.
  task automatic s_hdr(input logic [7:0] vi, input logic [15:0] tl,
                       input logic [7:0] pr, input logic [15:0] ck,
                       input logic [31:0] dst);
    fb = slen;
    s_byte(vi, 1'b1);        s_byte(8'h00, 1'b1);
    s_byte(tl[15:8], 1'b1);  s_byte(tl[7:0], 1'b1);
    s_byte(8'h00, 1'b1);     s_byte(8'h00, 1'b1);
    s_byte(8'h40, 1'b1);     s_byte(8'h00, 1'b1);
    s_byte(8'h40, 1'b1);     s_byte(pr, 1'b1);
    s_byte(ck[15:8], 1'b1);  s_byte(ck[7:0], 1'b1);
    s_byte(8'hC0, 1'b1);     s_byte(8'hA8, 1'b1);
    s_byte(8'h01, 1'b1);     s_byte(8'h01, 1'b1);
    s_byte(dst[31:24], 1'b1); s_byte(dst[23:16], 1'b1);
    s_byte(dst[15:8], 1'b1);  s_byte(dst[7:0], 1'b1);
    if (vi[3:0] == 4'd6)
      for (int i = 0; i < 4; i++) s_byte(8'h00, 1'b1);
  endtask

  // Drives the stream on falling edges; optionally pulses reset at entry rst_at.
  task automatic run(input int rst_at);
    mon_clear();
    for (int i = 0; i < slen; i++) begin
      @(negedge RX_CLK);
      if (rst_at >= 0 && i == rst_at) begin
        pre_udp = rx_data_udp;
        rst = 1'b1;
        #1;
        snap_flags = {rx_data_udp, rx_data_tcp, rx_data_last, rx_drop, rx_trunc};
        snap_data  = rx_data;
        snap_len   = rx_data_len;
        snap_src   = rx_src_ip;
        mon_clear();
      end
      if (rst_at >= 0 && i == rst_at + 1) rst = 1'b0;
      in_idx          = i;
      rx_payload_ipv4 = sv[i];
      rx_payload      = sb[i];
    end
    repeat (3) begin
      @(negedge RX_CLK);
      rx_payload_ipv4 = 1'b0;
      rx_payload      = 8'h00;
    end
  endtask

  task automatic good_udp();
    s_hdr(8'h45, 16'h001C, 8'h11, 16'hB775, MY_IP);
    s_pay(8, 8'h00);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    in_idx = 0;
    sb[0] = 8'h00;
    rst = 1'b1;
    ip_addr = MY_IP;
    rx_payload_ipv4 = 1'b0;
    rx_payload = 8'h00;
    mon_clear();
    repeat (3) @(negedge RX_CLK);
    chk("rst_flags", 32'({rx_data_udp, rx_data_tcp, rx_data_last, rx_drop, rx_trunc}), 32'h0);
    chk("rst_data", 32'(rx_data), 32'h0);
    chk("rst_len", 32'(rx_data_len), 32'h0);
    chk("rst_src", rx_src_ip, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge RX_CLK);

    // Valid UDP datagram followed by Ethernet padding.
    s_new(); s_gap(2); good_udp(); s_pad(18); s_gap(2);
    run(-1);
    chk("udp_cnt", n_udp, 8);
    chk("udp_tcp_cnt", n_tcp, 0);
    chk("udp_first", first_idx, fb + 20);
    chk("udp_data", n_dbad, 0);
    chk("udp_runs", n_runs, 1);
    chk("udp_last_cnt", n_last, 1);
    chk("udp_last_idx", last_idx, fb + 27);
    chk("udp_last_strobe", n_last_bad, 0);
    chk("udp_len", 32'(rx_data_len), 8);
    chk("udp_src", rx_src_ip, 32'hC0A8_0101);
    chk("udp_drop", n_drop, 0);

    // Bad checksum.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h001C, 8'h11, 16'hB776, MY_IP);
    s_pay(8, 8'h00); s_gap(2);
    run(-1);
    chk("cks_strobes", n_udp + n_tcp, 0);
    chk("cks_drop", n_drop, 1);
    chk("cks_drop_idx", drop_idx, fb + 19);
    chk("cks_len_held", 32'(rx_data_len), 8);

    // Destination mismatch, checksum consistent.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h001C, 8'h11, 16'hB774, 32'hC0A8_010B);
    s_pay(8, 8'h00); s_gap(2);
    run(-1);
    chk("dst_strobes", n_udp + n_tcp, 0);
    chk("dst_drop", n_drop, 1);

    // Broadcast destination.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h001C, 8'h11, 16'h7928, 32'hFFFF_FFFF);
    s_pay(8, 8'h30); s_gap(2);
    run(-1);
    chk("bc_cnt", n_udp, 8);
    chk("bc_data", n_dbad, 0);
    chk("bc_drop", n_drop, 0);

    // TCP datagram.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h001C, 8'h06, 16'hB780, MY_IP);
    s_pay(8, 8'h50); s_gap(2);
    run(-1);
    chk("tcp_cnt", n_tcp, 8);
    chk("tcp_udp_cnt", n_udp, 0);
    chk("tcp_data", n_dbad, 0);
    chk("tcp_last_idx", last_idx, fb + 27);

    // IHL 6 with options.
    s_new(); s_gap(2); s_hdr(8'h46, 16'h0020, 8'h11, 16'hB671, MY_IP);
    s_pay(8, 8'h70); s_pad(4); s_gap(2);
    run(-1);
    chk("opt_cnt", n_udp, 8);
    chk("opt_first", first_idx, fb + 24);
    chk("opt_last_idx", last_idx, fb + 31);
    chk("opt_len", 32'(rx_data_len), 8);
    chk("opt_data", n_dbad, 0);

    // Zero-length payload.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h0014, 8'h11, 16'hB77D, MY_IP);
    s_pad(6); s_gap(2);
    run(-1);
    chk("zero_strobes", n_udp + n_tcp, 0);
    chk("zero_drop", n_drop, 0);
    chk("zero_last", n_last, 0);
    chk("zero_len", 32'(rx_data_len), 0);

    // Truncated after four payload bytes.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h001C, 8'h11, 16'hB775, MY_IP);
    s_pay(4, 8'h00); s_gap(3);
    run(-1);
    chk("trunc_cnt", n_udp, 4);
    chk("trunc_last", n_last, 0);
    chk("trunc_pulse", n_trunc, 1);
    chk("trunc_idx", trunc_idx, fb + 24);
    chk("trunc_drop", n_drop, 0);

    // Header cut short.
    s_new(); s_gap(2); s_hdr(8'h45, 16'h001C, 8'h11, 16'hB775, MY_IP);
    slen = fb + 10;
    s_gap(3);
    run(-1);
    chk("hcut_drop", n_drop, 1);
    chk("hcut_drop_idx", drop_idx, fb + 10);

    // Back-to-back datagrams with one idle cycle between.
    s_new(); s_gap(2); good_udp(); s_gap(1);
    s_hdr(8'h45, 16'h001C, 8'h06, 16'hB780, MY_IP); s_pay(8, 8'h10); s_gap(2);
    run(-1);
    chk("b2b_udp", n_udp, 8);
    chk("b2b_tcp", n_tcp, 8);
    chk("b2b_last", n_last, 2);
    chk("b2b_runs", n_runs, 2);
    chk("b2b_data", n_dbad, 0);
    chk("b2b_last_idx", last_idx, fb + 27);

    // Reset in the middle of the payload; rest of that frame must be ignored.
    s_new(); s_gap(2); good_udp(); s_pad(6); s_gap(2);
    run(fb + 24);
    chk("mrst_pre_strobe", 32'(pre_udp), 1);
    chk("mrst_flags", 32'(snap_flags), 0);
    chk("mrst_data", 32'(snap_data), 0);
    chk("mrst_len", 32'(snap_len), 0);
    chk("mrst_src", snap_src, 0);
    chk("mrst_after_strobes", n_udp + n_tcp, 0);
    chk("mrst_after_drop", n_drop, 0);

    // Recovery after reset.
    s_new(); s_gap(1); good_udp(); s_gap(2);
    run(-1);
    chk("rec_cnt", n_udp, 8);
    chk("rec_data", n_dbad, 0);
    chk("rec_len", 32'(rx_data_len), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule
